// File: rtl/mips_pkg.sv
// Shared types and control-field encodings for the multicycle MIPS sequencer.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_JUMP  = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef enum logic [3:0] {
        RST_S  = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12
    } mc_state_t;

    localparam logic [1:0] ALUSRCB_RT      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic is_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_JUMP, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the sequencer, the IR/memory side and the datapath controls.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_retired;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state_o;

    modport master (
        input  opcode, mem_ready,
        output memread, memwrite, iord, irwrite, pcwrite, branch_eq, branch_ne,
               pcsrc, alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
               instr_retired, illegal_op, bus_error, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  memread, memwrite, iord, irwrite, pcwrite, branch_eq, branch_ne,
               pcsrc, alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
               instr_retired, illegal_op, bus_error, state_o
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory state and flags the abort cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // Clear wins over tick; the count saturates instead of wrapping.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (tick && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired = (MEM_TIMEOUT > 0) && tick && (wait_cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for multicycle MIPS: lw, sw, addi, beq, bne, R-type, j.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    mc_state_t state_q;
    mc_state_t state_d;
    logic      mem_wait;
    logic      tmr_clear;
    logic      tmr_tick;
    logic      tmr_expired;

    assign mem_wait  = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign tmr_tick  = mem_wait && !bus.mem_ready;
    // An abort that lands back in FETCH is a fresh entry, so it clears too.
    assign tmr_clear = (state_d != state_q) || tmr_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .tick   (tmr_tick),
        .expired(tmr_expired)
    );

    // Next-state selection; mem_ready always beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_S: state_d = FETCH;
            FETCH: begin
                if (bus.mem_ready)       state_d = DECODE;
                else if (tmr_expired)    state_d = FETCH;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_RTYPE:       state_d = EXEC;
                    OP_ADDI:        state_d = ADDIEX;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_JUMP:        state_d = JUMP;
                    default:        state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.opcode == OP_LW)      state_d = MEMRD;
                else if (bus.opcode == OP_SW) state_d = MEMWR;
                else                          state_d = FETCH;
            end
            MEMRD: begin
                if (bus.mem_ready)       state_d = MEMWB;
                else if (tmr_expired)    state_d = FETCH;
            end
            MEMWR: begin
                if (bus.mem_ready || tmr_expired) state_d = FETCH;
            end
            EXEC:    state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // State register; reset forces RST_S, whose decode is all zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_S;
        end else begin
            state_q <= state_d;
        end
    end

    // Control decode from the current state (FETCH loads gated by mem_ready).
    always_comb begin
        bus.memread       = 1'b0;
        bus.memwrite      = 1'b0;
        bus.iord          = 1'b0;
        bus.irwrite       = 1'b0;
        bus.pcwrite       = 1'b0;
        bus.branch_eq     = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pcsrc         = PCSRC_ALU;
        bus.alusrca       = 1'b0;
        bus.alusrcb       = ALUSRCB_RT;
        bus.aluop         = ALUOP_ADD;
        bus.regdst        = 1'b0;
        bus.memtoreg      = 1'b0;
        bus.regwrite      = 1'b0;
        bus.instr_retired = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.bus_error     = 1'b0;
        case (state_q)
            FETCH: begin
                bus.memread   = 1'b1;
                bus.alusrcb   = ALUSRCB_FOUR;
                bus.irwrite   = bus.mem_ready;
                bus.pcwrite   = bus.mem_ready;
                bus.bus_error = tmr_expired;
            end
            DECODE: begin
                bus.alusrcb    = ALUSRCB_IMM_SH2;
                bus.illegal_op = !is_supported(bus.opcode);
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUSRCB_IMM;
            end
            MEMRD: begin
                bus.memread   = 1'b1;
                bus.iord      = 1'b1;
                bus.bus_error = tmr_expired;
            end
            MEMWB: begin
                bus.memtoreg      = 1'b1;
                bus.regwrite      = 1'b1;
                bus.instr_retired = 1'b1;
            end
            MEMWR: begin
                bus.memwrite      = 1'b1;
                bus.iord          = 1'b1;
                bus.instr_retired = bus.mem_ready;
                bus.bus_error     = tmr_expired;
            end
            EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                bus.regdst        = 1'b1;
                bus.regwrite      = 1'b1;
                bus.instr_retired = 1'b1;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUSRCB_IMM;
            end
            ADDIWB: begin
                bus.regwrite      = 1'b1;
                bus.instr_retired = 1'b1;
            end
            BRANCH: begin
                bus.alusrca       = 1'b1;
                bus.aluop         = ALUOP_SUB;
                bus.pcsrc         = PCSRC_ALUOUT;
                bus.branch_eq     = (bus.opcode == OP_BEQ);
                bus.branch_ne     = (bus.opcode == OP_BNE);
                bus.instr_retired = 1'b1;
            end
            JUMP: begin
                bus.pcsrc         = PCSRC_JUMP;
                bus.pcwrite       = 1'b1;
                bus.instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state_o = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle MIPS sequencer. It replaces single-cycle opcode decoding with a Moore FSM that steps one shared ALU and one unified memory port through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK. It sits between the instruction register (opcode source), the shared memory interface (req/ready handshake) and the datapath mux/enable controls. It supports the opcode set lw, sw, addi, beq, bne, R-type add and j.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory state waits for mem_ready before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  instruction[31:26] from IR; valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
memread  out  1  memory read request (held until ready)
memwrite  out  1  memory write request (held until ready)
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
irwrite  out  1  load IR
pcwrite  out  1  unconditional PC load
branch_eq  out  1  PC load if ALU zero
branch_ne  out  1  PC load if not zero
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
alusrca  out  1  0 PC, 1 rs
alusrcb  out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
aluop  out  2  00 add, 01 sub, 10 funct-decoded
regdst  out  1  1 rd, 0 rt
memtoreg  out  1  1 MDR, 0 ALUOut
regwrite  out  1  register file write
instr_retired  out  1  one-cycle pulse on last cycle of each instruction
illegal_op  out  1  one-cycle pulse, unsupported opcode in DECODE
bus_error  out  1  one-cycle pulse, memory timeout
state_o  out  4  current state encoding, for debug

Behaviour:
- States: RST_S, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
- Reset: state := RST_S asynchronously. All outputs 0 in RST_S, so asserting reset mid-access drops memread/memwrite immediately. RST_S always moves to FETCH on the next edge.
- Outputs are pure Moore decodes of state, except irwrite/pcwrite in FETCH, which are gated by mem_ready. Outputs not listed for a state are 0.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. In the mem_ready cycle, irwrite=1 and pcwrite=1, and the next state is DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 001000 -> ADDIEX
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - any other -> FETCH with illegal_op=1 and instr_retired=0.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD if lw, MEMWR if sw.
- MEMRD: memread=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, retire. Next FETCH.
- MEMWR: memwrite=1, iord=1. On mem_ready, retire and go to FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next ALUWB.
- ALUWB: regdst=1, regwrite=1, retire. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next ADDIWB.
- ADDIWB: regdst=0, regwrite=1, retire. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01. branch_eq=1 for 000100, branch_ne=1 for 000101. Retire, then FETCH.
- JUMP: pcsrc=10, pcwrite=1, retire. Next FETCH.
- Opcode is re-sampled in MEMADR and BRANCH; IR is stable because irwrite=0 outside FETCH.
- Timeout (FETCH, MEMRD, MEMWR):
  - wait_cnt clears on entry to the state and increments each cycle mem_ready=0.
  - If MEM_TIMEOUT>0, mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: bus_error=1 that cycle and next state FETCH. No irwrite/pcwrite/regwrite; no retire.
  - mem_ready=1 always wins over timeout.
  - wait_cnt width is $clog2(MEM_TIMEOUT+1) and it saturates, never wraps.
- Latency, zero-wait memory: lw 5, sw 4, R/addi 4, branch/jump 3 cycles.

Decomposition:
- Package mips_pkg holds:
  - opcode_t enum: LW, SW, ADDI, BEQ, BNE, RTYPE, JUMP.
  - mc_state_t enum (4-bit).
  - ALUSRCB_* constants.
  - PCSRC_* constants.
  - ALUOP_ADD/SUB/FUNCT constants.
- Sub-module mem_wait_timer (clk, reset, clear, tick, expired; parameter MEM_TIMEOUT) holds the timeout counter.
- The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset, then lw with mem_ready=1 always. state_o sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. In MEMWB, regwrite=1, memtoreg=1, regdst=0. Exactly one instr_retired pulse.
- sw with mem_ready low 3 cycles in MEMWR. memwrite=1 for 4 consecutive cycles with iord=1. Retire on the ready cycle. regwrite never 1.
- beq then bne. BRANCH asserts aluop=01, pcsrc=01, and branch_eq=1 (beq) or branch_ne=1 (bne), never both. Each instruction takes 3 cycles.
- opcode=6'b111111. illegal_op pulses in DECODE and the next state is FETCH. No regwrite, memwrite or instr_retired.
- MEM_TIMEOUT=4 with mem_ready held 0 in MEMRD. bus_error=1 on the 4th MEMRD cycle, then FETCH. No regwrite. With MEM_TIMEOUT=0, waits 50 cycles without error.
- reset asserted mid-MEMWR between clock edges. memwrite falls combinationally and all outputs are 0. One cycle after deassert, state=FETCH with memread=1.
